// File: rtl/accum_pkg.sv
// Shared types and constants for the carry-save realignment accumulator.
// The defaults mirror the squarer datapath configuration.
package accum_pkg;

  localparam int DEF_NUM_DIGITS = 130;
  localparam int DEF_CHUNK      = 10;
  localparam int DEF_DIGIT_W    = 16;
  localparam int DEF_IN_W       = 23;
  localparam int DEF_ADD2_W     = 17;
  localparam int DEF_OUT_W      = 19;

  localparam int BEATS = DEF_NUM_DIGITS / DEF_CHUNK;
  localparam int HI_W  = DEF_IN_W - DEF_DIGIT_W;

  typedef logic [DEF_IN_W-1:0]   in_digit_t;
  typedef logic [DEF_ADD2_W-1:0] add_digit_t;
  typedef logic [DEF_OUT_W-1:0]  out_digit_t;

  typedef enum logic {IDLE, RUN} seq_state_t;

  // True when the worst-case five-term digit sum fits in out_w bits.
  function automatic bit out_width_ok(input int digit_w, input int hi_w,
                                      input int add2_w, input int out_w);
    longint worst;
    worst = 2 * ((longint'(1) << digit_w) - 1)
          + 2 * ((longint'(1) << hi_w) - 1)
          + ((longint'(1) << add2_w) - 1);
    return worst < (longint'(1) << out_w);
  endfunction

endpackage

// File: rtl/accum_realign_seq_csa.sv
// Combinational five-input carry-save compressor built from three 3:2 stages.
// Carries shifted out of the top bit are always zero while the true sum fits in OUT_W.
module csa_5to2 #(
  parameter int OUT_W = 19
) (
  input  logic [OUT_W-1:0] a,
  input  logic [OUT_W-1:0] b,
  input  logic [OUT_W-1:0] c,
  input  logic [OUT_W-1:0] d,
  input  logic [OUT_W-1:0] e,
  output logic [OUT_W-1:0] sum,
  output logic [OUT_W-1:0] carry
);

  logic [OUT_W-1:0] s1, m1, c1, s2, m2, c2, m3;

  assign s1 = a ^ b ^ c;
  assign m1 = (a & b) | (a & c) | (b & c);
  assign c1 = m1 << 1;

  assign s2 = s1 ^ c1 ^ d;
  assign m2 = (s1 & c1) | (s1 & d) | (c1 & d);
  assign c2 = m2 << 1;

  assign sum   = s2 ^ c2 ^ e;
  assign m3    = (s2 & c2) | (s2 & e) | (c2 & e);
  assign carry = m3 << 1;

endmodule

// File: rtl/accum_realign_seq.sv
// Time-multiplexed realignment accumulator: CHUNK digits per beat, carry-save output
// with the inter-beat high-bit carry held in cry_c/cry_s.
module accum_realign_seq
  import accum_pkg::*;
#(
  parameter int NUM_DIGITS = 130,
  parameter int CHUNK      = 10,
  parameter int DIGIT_W    = 16,
  parameter int IN_W       = 23,
  parameter int ADD2_W     = 17,
  parameter int OUT_W      = 19
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        extend,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_first,
  input  logic [CHUNK*IN_W-1:0]       in_c,
  input  logic [CHUNK*IN_W-1:0]       in_s,
  input  logic [CHUNK*ADD2_W-1:0]     in_add2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHUNK*OUT_W-1:0]      out_c,
  output logic [CHUNK*OUT_W-1:0]      out_s,
  output logic                        out_last,
  output logic [((NUM_DIGITS/CHUNK) > 1 ? $clog2(NUM_DIGITS/CHUNK) : 1)-1:0] out_beat,
  output logic [IN_W-DIGIT_W-1:0]     out_ovf_c,
  output logic [IN_W-DIGIT_W-1:0]     out_ovf_s,
  output logic                        frame_err
);

  localparam int N_BEATS = NUM_DIGITS / CHUNK;
  localparam int H_W     = IN_W - DIGIT_W;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  if (NUM_DIGITS % CHUNK != 0) begin : g_bad_chunk
    $fatal(1, "CHUNK must divide NUM_DIGITS");
  end
  if (!out_width_ok(DIGIT_W, H_W, ADD2_W, OUT_W)) begin : g_bad_width
    $fatal(1, "OUT_W too narrow for the five-term digit sum");
  end

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_base, cnt_nxt;
  logic [H_W-1:0]   cry_c, cry_s, cin_c, cin_s;
  logic             ext_q, ext_eff, accept, at_start, beat0, is_last, bad_frame;
  logic [CHUNK*OUT_W-1:0] lane_c, lane_s;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Any beat that starts a frame (flagged or not) restarts the count and clears carry-in.
  always_comb begin
    at_start  = (state == IDLE);
    beat0     = in_first || at_start;
    bad_frame = in_first != at_start;
    cnt_base  = beat0 ? '0 : cnt;
    is_last   = (cnt_base == CNT_W'(N_BEATS - 1));
    ext_eff   = beat0 ? extend : ext_q;
    cin_c     = beat0 ? '0 : cry_c;
    cin_s     = beat0 ? '0 : cry_s;
    cnt_nxt   = cnt;
    state_nxt = state;
    if (accept) begin
      cnt_nxt   = is_last ? '0 : cnt_base + CNT_W'(1);
      state_nxt = is_last ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  for (genvar j = 0; j < CHUNK; j++) begin : g_lane
    logic [H_W-1:0] hp_c, hp_s;
    if (j == 0) begin : g_head
      assign hp_c = cin_c;
      assign hp_s = cin_s;
    end else begin : g_body
      assign hp_c = in_c[(j-1)*IN_W + DIGIT_W +: H_W];
      assign hp_s = in_s[(j-1)*IN_W + DIGIT_W +: H_W];
    end
    csa_5to2 #(.OUT_W(OUT_W)) u_csa (
      .a    (OUT_W'(in_c[j*IN_W +: DIGIT_W])),
      .b    (OUT_W'(in_s[j*IN_W +: DIGIT_W])),
      .c    (OUT_W'(hp_c)),
      .d    (OUT_W'(hp_s)),
      .e    (OUT_W'(in_add2[j*ADD2_W +: ADD2_W])),
      .sum  (lane_s[j*OUT_W +: OUT_W]),
      .carry(lane_c[j*OUT_W +: OUT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_s     <= '0;
      out_last  <= 1'b0;
      out_beat  <= '0;
      out_ovf_c <= '0;
      out_ovf_s <= '0;
      frame_err <= 1'b0;
      cnt       <= '0;
      cry_c     <= '0;
      cry_s     <= '0;
      ext_q     <= 1'b0;
    end else begin
      frame_err <= accept && bad_frame;
      if (in_ready) out_valid <= in_valid;
      if (accept) begin
        out_c     <= lane_c;
        out_s     <= lane_s;
        out_beat  <= cnt_base;
        out_last  <= is_last;
        out_ovf_c <= (is_last && ext_eff) ? in_c[CHUNK*IN_W-1 -: H_W] : '0;
        out_ovf_s <= (is_last && ext_eff) ? in_s[CHUNK*IN_W-1 -: H_W] : '0;
        cnt       <= cnt_nxt;
        cry_c     <= in_c[CHUNK*IN_W-1 -: H_W];
        cry_s     <= in_s[CHUNK*IN_W-1 -: H_W];
        if (beat0) ext_q <= extend;
      end
    end
  end

endmodule

// File: tb/tb_accum_realign_seq.sv
// Directed bench for accum_realign_seq: uniform-digit frame table, boundary carry,
// backpressure, framing errors and mid-frame reset against hand values and a digit model.
module tb_accum_realign_seq;

  localparam int NUM_DIGITS = 130;
  localparam int CHUNK      = 10;
  localparam int DIGIT_W    = 16;
  localparam int IN_W       = 23;
  localparam int ADD2_W     = 17;
  localparam int OUT_W      = 19;
  localparam int BEATS      = 13;
  localparam int HI_W       = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset = 1'b1, extend = 1'b0, in_valid = 1'b0, in_first = 1'b0;
  logic                    out_ready = 1'b1;
  logic [CHUNK*IN_W-1:0]   in_c = '0, in_s = '0;
  logic [CHUNK*ADD2_W-1:0] in_add2 = '0;
  logic                    in_ready, out_valid, out_last, frame_err;
  logic [CHUNK*OUT_W-1:0]  out_c, out_s;
  logic [3:0]              out_beat;
  logic [HI_W-1:0]         out_ovf_c, out_ovf_s;

  accum_realign_seq #(
    .NUM_DIGITS(NUM_DIGITS), .CHUNK(CHUNK), .DIGIT_W(DIGIT_W),
    .IN_W(IN_W), .ADD2_W(ADD2_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset(reset), .extend(extend), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_c(in_c), .in_s(in_s), .in_add2(in_add2),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_s(out_s),
    .out_last(out_last), .out_beat(out_beat), .out_ovf_c(out_ovf_c),
    .out_ovf_s(out_ovf_s), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [CHUNK*IN_W-1:0]   c;
    logic [CHUNK*IN_W-1:0]   s;
    logic [CHUNK*ADD2_W-1:0] add2;
    logic                    first;
    logic                    ext;
  } stim_t;

  typedef struct packed {
    logic [CHUNK-1:0][OUT_W:0] sum;
    logic [3:0]                beat;
    logic                      last;
    logic [HI_W-1:0]           ovf_c;
    logic [HI_W-1:0]           ovf_s;
    logic                      ferr;
  } exp_t;

  typedef struct packed {
    logic [IN_W-1:0]   c_dig;
    logic [IN_W-1:0]   s_dig;
    logic [ADD2_W-1:0] a_dig;
    logic              ext;
    logic [OUT_W:0]    exp_d0;
    logic [OUT_W:0]    exp_dn;
    logic [HI_W-1:0]   exp_ovf_c;
    logic [HI_W-1:0]   exp_ovf_s;
  } vec_t;

  stim_t stim[$];
  exp_t  exp_q[$];
  vec_t  tbl[5];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic push_beat(input logic [CHUNK*IN_W-1:0] c, input logic [CHUNK*IN_W-1:0] s,
                           input logic [CHUNK*ADD2_W-1:0] a, input logic first,
                           input logic ext);
    stim_t st;
    st.c = c; st.s = s; st.add2 = a; st.first = first; st.ext = ext;
    stim.push_back(st);
  endtask

  task automatic push_random_beat(input logic first, input logic ext);
    logic [CHUNK*IN_W-1:0]   c, s;
    logic [CHUNK*ADD2_W-1:0] a;
    for (int j = 0; j < CHUNK; j++) begin
      c[j*IN_W +: IN_W]     = IN_W'($urandom);
      s[j*IN_W +: IN_W]     = IN_W'($urandom);
      a[j*ADD2_W +: ADD2_W] = ADD2_W'($urandom);
    end
    push_beat(c, s, a, first, ext);
  endtask

  task automatic push_uniform_frame(input vec_t v);
    for (int b = 0; b < BEATS; b++)
      push_beat({CHUNK{v.c_dig}}, {CHUNK{v.s_dig}}, {CHUNK{v.a_dig}}, b == 0, v.ext);
  endtask

  task automatic build_uniform_exp(input logic [OUT_W:0] d0, input logic [OUT_W:0] dn,
                                   input logic [HI_W-1:0] oc, input logic [HI_W-1:0] os);
    exp_t e;
    exp_q.delete();
    for (int b = 0; b < BEATS; b++) begin
      e = '0;
      for (int j = 0; j < CHUNK; j++) e.sum[j] = dn;
      if (b == 0) e.sum[0] = d0;
      e.beat = 4'(b);
      e.last = (b == BEATS - 1);
      e.ovf_c = e.last ? oc : '0;
      e.ovf_s = e.last ? os : '0;
      exp_q.push_back(e);
    end
  endtask

  // Digit-level reference: exact integer sum of the five terms per digit.
  task automatic build_model();
    int cnt = 0;
    logic [HI_W-1:0] cc = '0, cs = '0;
    logic ext = 1'b0;
    exp_q.delete();
    foreach (stim[k]) begin
      stim_t st;
      exp_t  e;
      logic  b0;
      int    pc, ps;
      st = stim[k];
      e  = '0;
      b0 = st.first || (cnt == 0);
      e.ferr = st.first != (cnt == 0);
      if (b0) begin cnt = 0; cc = '0; cs = '0; ext = st.ext; end
      for (int j = 0; j < CHUNK; j++) begin
        pc = (j == 0) ? int'(cc) : int'(st.c[(j-1)*IN_W + DIGIT_W +: HI_W]);
        ps = (j == 0) ? int'(cs) : int'(st.s[(j-1)*IN_W + DIGIT_W +: HI_W]);
        e.sum[j] = 20'(int'(st.c[j*IN_W +: DIGIT_W]) + int'(st.s[j*IN_W +: DIGIT_W])
                       + pc + ps + int'(st.add2[j*ADD2_W +: ADD2_W]));
      end
      e.beat = 4'(cnt);
      e.last = (cnt == BEATS - 1);
      if (e.last && ext) begin
        e.ovf_c = st.c[CHUNK*IN_W-1 -: HI_W];
        e.ovf_s = st.s[CHUNK*IN_W-1 -: HI_W];
      end
      cc  = st.c[CHUNK*IN_W-1 -: HI_W];
      cs  = st.s[CHUNK*IN_W-1 -: HI_W];
      cnt = e.last ? 0 : cnt + 1;
      exp_q.push_back(e);
    end
  endtask

  // Drives stim[] beat by beat and checks each consumed output against exp_q.
  task automatic applyStimulus(input int ready_pct);
    int idx = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic accepted;
    logic [2*CHUNK*OUT_W+4+1+2*HI_W-1:0] saved = '0;
    exp_t e;
    while ((idx < stim.size() || exp_q.size() > 0) && cyc < 3000) begin
      if (idx < stim.size()) begin
        in_valid = 1'b1;
        in_c = stim[idx].c; in_s = stim[idx].s; in_add2 = stim[idx].add2;
        in_first = stim[idx].first; extend = stim[idx].ext;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      checkOutput("in_ready", in_ready, !out_valid || out_ready);
      checkOutput("frame_err", frame_err,
                  (out_valid && !held && exp_q.size() > 0) ? exp_q[0].ferr : 1'b0);
      if (out_valid && held)
        checkOutput("stall hold",
                    {out_c, out_s, out_beat, out_last, out_ovf_c, out_ovf_s} === saved, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected beat", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          for (int j = 0; j < CHUNK; j++)
            checkOutput($sformatf("beat %0d digit %0d C+S", e.beat, j),
                        64'(out_c[j*OUT_W +: OUT_W]) + 64'(out_s[j*OUT_W +: OUT_W]),
                        64'(e.sum[j]));
          checkOutput("out_beat", out_beat, e.beat);
          checkOutput("out_last", out_last, e.last);
          checkOutput("out_ovf_c", out_ovf_c, e.ovf_c);
          checkOutput("out_ovf_s", out_ovf_s, e.ovf_s);
        end
      end
      held  = out_valid && !out_ready;
      saved = {out_c, out_s, out_beat, out_last, out_ovf_c, out_ovf_s};
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) idx++;
      cyc++;
    end
    if (cyc >= 3000) checkOutput("cycle budget exhausted", 1, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("drain out_valid", out_valid, 0);
    @(posedge clk); #1;
    stim.delete();
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{23'h7FFFFF, 23'h7FFFFF, 17'h1FFFF, 1'b0, 20'h3FFFD, 20'h400FB, 7'h00, 7'h00};
    tbl[1] = '{23'h7FFFFF, 23'h7FFFFF, 17'h1FFFF, 1'b1, 20'h3FFFD, 20'h400FB, 7'h7F, 7'h7F};
    tbl[2] = '{23'h123456, 23'h00ABCD, 17'h00001, 1'b1, 20'h0E024, 20'h0E036, 7'h12, 7'h00};
    tbl[3] = '{23'h000000, 23'h000000, 17'h00000, 1'b0, 20'h00000, 20'h00000, 7'h00, 7'h00};
    tbl[4] = '{23'h7F0000, 23'h010000, 17'h00000, 1'b1, 20'h00000, 20'h00080, 7'h7F, 7'h01};

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_c|out_s", |{out_c, out_s}, 0);
    checkOutput("reset out_beat/last/ovf", {out_beat, out_last, out_ovf_c, out_ovf_s}, 0);
    checkOutput("reset frame_err", frame_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] uniform frame table");
    for (int t = 0; t < 5; t++) begin
      push_uniform_frame(tbl[t]);
      build_uniform_exp(tbl[t].exp_d0, tbl[t].exp_dn, tbl[t].exp_ovf_c, tbl[t].exp_ovf_s);
      applyStimulus(100);
    end

    $display("[TB] beat boundary carry");
    begin
      logic [CHUNK*IN_W-1:0] c;
      exp_t e;
      for (int b = 0; b < BEATS; b++) begin
        c = '0;
        if (b == 3) c[CHUNK*IN_W-1 -: HI_W] = 7'h55;
        push_beat(c, '0, '0, b == 0, 1'b0);
      end
      build_uniform_exp('0, '0, '0, '0);
      e = exp_q[4];
      e.sum[0] = 20'h55;
      exp_q[4] = e;
      applyStimulus(100);
    end

    $display("[TB] backpressure over three frames");
    for (int f = 0; f < 3; f++)
      for (int b = 0; b < BEATS; b++) push_random_beat(b == 0, f != 0);
    build_model();
    applyStimulus(30);

    $display("[TB] in_first on beat 5");
    for (int b = 0; b < 5; b++) push_random_beat(b == 0, 1'b0);
    for (int b = 0; b < BEATS; b++) push_random_beat(b == 0, 1'b1);
    build_model();
    applyStimulus(100);

    $display("[TB] missing in_first on beat 0");
    for (int b = 0; b < BEATS; b++) push_random_beat(1'b0, 1'b1);
    build_model();
    applyStimulus(100);

    $display("[TB] reset at beat 7");
    for (int b = 0; b < 7; b++) push_random_beat(b == 0, 1'b1);
    build_model();
    applyStimulus(100);
    in_valid = 1'b1; in_first = 1'b0; in_c = '1; in_s = '1; in_add2 = '1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post-reset out_valid", out_valid, 0);
    checkOutput("post-reset out_c|out_s", |{out_c, out_s}, 0);
    checkOutput("post-reset beat/last/ovf", {out_beat, out_last, out_ovf_c, out_ovf_s}, 0);
    checkOutput("post-reset frame_err", frame_err, 0);
    @(posedge clk); #1;
    for (int b = 0; b < BEATS; b++) push_random_beat(b == 0, 1'b1);
    build_model();
    applyStimulus(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
